// File: rtl/bcd_seven_segment_pkg.sv
// bcd_seven_segment_pkg: shared segment width and glyph constants (abcdefg, 1 = lit)
package bcd_seven_segment_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/bcd_seven_segment_lut.sv
// seg_decode_lut: combinational 4-bit digit to abcdefg segment lookup
// Ports: digit (4-bit code in), seg (7-bit segment pattern out)
// Macro BCD_SEVEN_SEGMENT_HEX_EN: codes 10-15 show hex glyphs instead of blank
module seg_decode_lut
    import bcd_seven_segment_pkg::*;
(
    input  logic [3:0]       digit,
    output logic [SEG_W-1:0] seg
);
    // Any code without a row, including X/Z, falls through to blank
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
`ifdef BCD_SEVEN_SEGMENT_HEX_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_seven_segment.sv
// bcd_seven_segment: registered BCD to common-cathode seven-segment decoder
// Ports: clk, rst (sync active-high), inp (4-bit digit), out (7-bit abcdefg, 1 = lit)
// Macro BCD_SEVEN_SEGMENT_HEX_EN: codes 10-15 show hex glyphs instead of blank
module bcd_seven_segment
    import bcd_seven_segment_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       inp,
    output logic [SEG_W-1:0] out
);
    logic [SEG_W-1:0] seg;
    logic [SEG_W-1:0] out_d;
    logic [SEG_W-1:0] out_q;
    seg_decode_lut u_lut (
        .digit(inp),
        .seg  (seg)
    );
    always_comb out_d = rst ? SEG_BLANK : seg;
    always_ff @(posedge clk) out_q <= out_d;
    assign out = out_q;
endmodule

// File: tb/tb_bcd_seven_segment.sv
// tb_bcd_seven_segment: table-driven check of the registered segment decoder
module tb_bcd_seven_segment;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] inp = 4'd8;
    logic [6:0] out;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       r;
        logic [3:0] d;
        logic [6:0] e;
    } vec_t;

`ifdef BCD_SEVEN_SEGMENT_HEX_EN
    localparam logic [6:0] EXP_10 = 7'b1110111;
    localparam logic [6:0] EXP_15 = 7'b1000111;
`else
    localparam logic [6:0] EXP_10 = 7'b0000000;
    localparam logic [6:0] EXP_15 = 7'b0000000;
`endif

    bcd_seven_segment dut (
        .clk(clk),
        .rst(rst),
        .inp(inp),
        .out(out)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [6:0] exp);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s: out=%b required=%b", name, out, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] d);
        @(negedge clk);
        rst = r;
        inp = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{1'b1, 4'd8, 7'b0000000},
            '{1'b1, 4'd8, 7'b0000000},
            '{1'b0, 4'd8, 7'b1111111},
            '{1'b0, 4'd1, 7'b0110000},
            '{1'b0, 4'd2, 7'b1101101},
            '{1'b0, 4'd3, 7'b1111001},
            '{1'b0, 4'd4, 7'b0110011},
            '{1'b0, 4'd5, 7'b1011011},
            '{1'b0, 4'd6, 7'b1011111},
            '{1'b0, 4'd7, 7'b1110000},
            '{1'b0, 4'd8, 7'b1111111},
            '{1'b0, 4'd9, 7'b1111011},
            '{1'b0, 4'd0, 7'b1111110},
            '{1'b0, 4'd10, EXP_10},
            '{1'b0, 4'd15, EXP_15},
            '{1'b0, 4'd5, 7'b1011011},
            '{1'b1, 4'd5, 7'b0000000},
            '{1'b0, 4'd5, 7'b1011011},
            '{1'b1, 4'd9, 7'b0000000},
            '{1'b0, 4'd3, 7'b1111001}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d inp=%0d rst=%0b", i, vecs[i].d, vecs[i].r), vecs[i].e);
        end
        // Latency: inp changes just after an edge, out holds until the next edge
        step(1'b0, 4'd9);
        check("latency_pre", 7'b1111011);
        inp = 4'd0;
        #2;
        check("latency_hold", 7'b1111011);
        @(negedge clk);
        check("latency_hold_neg", 7'b1111011);
        @(posedge clk);
        #1;
        check("latency_zero", 7'b1111110);
        // Input glitches between edges never reach the output
        step(1'b0, 4'd2);
        check("glitch_base", 7'b1101101);
        #1 inp = 4'd3;
        #1;
        check("glitch_mid3", 7'b1101101);
        #1 inp = 4'd2;
        @(posedge clk);
        #1;
        check("glitch_after", 7'b1101101);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
